g_round_scheduler: RTL and testbench

- Sequences one shared, pipelined G mixing unit through a full BLAKE3-style compression of a 16-word state.
- Each round runs 4 column G ops, then 4 diagonal G ops, then permutes the message words.
- Holds the 16x32 working state and the 16x32 message, issues operands to the G unit, and writes results back.
- Sits between the miner's job/header loader and the G datapath; it replaces 8 parallel G instances with one time-shared unit.

---
 rtl/g_round_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_g_round_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/g_round_scheduler.sv
// Sequences one shared pipelined G unit through a full ROUNDS-round compression of a 16x32 state.
// Latency: Done_O rises 1 + 2*ROUNDS*(4+G_LATENCY) edges after the accepting edge. No backpressure: Start_I ignored while Busy_O.
// Optional G_SCHED_FINALIZE_EN: State_O carries the feed-forward output words instead of the raw state.
module g_round_scheduler #(
  parameter int ROUNDS    = 7,
  parameter int G_LATENCY = 3,
  parameter int Y_OFFSET  = 2
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start_I,
  input  logic [511:0] State_I,
  input  logic [511:0] Msg_I,
  output logic         Busy_O,
  output logic         Done_O,
  output logic [511:0] State_O,
  output logic [31:0]  G_A_O,
  output logic [31:0]  G_B_O,
  output logic [31:0]  G_C_O,
  output logic [31:0]  G_D_O,
  output logic [31:0]  G_X_O,
  output logic [31:0]  G_Y_O,
  input  logic [31:0]  G_A_I,
  input  logic [31:0]  G_B_I,
  input  logic [31:0]  G_C_I,
  input  logic [31:0]  G_D_I
);

  localparam int HALF = 4 + G_LATENCY;
  localparam int CW   = $clog2(HALF);
  localparam int YD   = (Y_OFFSET > 0) ? Y_OFFSET : 1;
  localparam logic [3:0] PERM [16] = '{4'd2, 4'd6, 4'd3, 4'd10, 4'd7, 4'd0, 4'd4, 4'd13,
                                       4'd1, 4'd11, 4'd12, 4'd5, 4'd9, 4'd14, 4'd15, 4'd8};

  typedef enum logic [2:0] {IDLE, COL_ISSUE, COL_WAIT, DIAG_ISSUE, DIAG_WAIT, FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    round_q;
  logic [31:0]   v_q [16];
  logic [31:0]   m_q [16];
  logic [31:0]   y_dly_q [YD];
  logic          done_q;
  logic [511:0]  state_o_q;
  logic [511:0]  fin_state;

  logic          diag_half, issue, active, wb, half_last;
  logic [1:0]    iss_op, wb_op;
  logic [15:0]   iss_q, wb_q;
  logic [3:0]    x_idx;
  logic [31:0]   y_now;

  // Packs the four state indices {d,c,b,a}; diagonal op j takes row r at column (j+r) mod 4.
  function automatic logic [15:0] quad(input logic diag, input logic [1:0] op);
    logic [1:0] c1, c2, c3;
    c1 = diag ? op + 2'd1 : op;
    c2 = diag ? op + 2'd2 : op;
    c3 = diag ? op + 2'd3 : op;
    return {2'd3, c3, 2'd2, c2, 2'd1, c1, 2'd0, op};
  endfunction

  always_comb begin
    diag_half = (state_q == DIAG_ISSUE) || (state_q == DIAG_WAIT);
    issue     = (state_q == COL_ISSUE) || (state_q == DIAG_ISSUE);
    active    = issue || (state_q == COL_WAIT) || (state_q == DIAG_WAIT);
    wb        = active && (cnt_q >= CW'(G_LATENCY));
    half_last = (cnt_q == CW'(HALF - 1));
    iss_op    = cnt_q[1:0];
    wb_op     = 2'(cnt_q - CW'(G_LATENCY));
    iss_q     = quad(diag_half, iss_op);
    wb_q      = quad(diag_half, wb_op);
    x_idx     = {diag_half, iss_op, 1'b0};
    y_now     = issue ? m_q[x_idx | 4'd1] : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (Start_I) state_d = COL_ISSUE;
      COL_ISSUE:  if (cnt_q == CW'(3)) state_d = COL_WAIT;
      COL_WAIT:   if (half_last) state_d = DIAG_ISSUE;
      DIAG_ISSUE: if (cnt_q == CW'(3)) state_d = DIAG_WAIT;
      DIAG_WAIT:  if (half_last) state_d = (round_q == 4'(ROUNDS - 1)) ? FIN : COL_ISSUE;
      FIN:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      done_q    <= 1'b0;
      state_o_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIN);
      if (state_q == FIN) state_o_q <= fin_state;
      // cnt_q spans one half-round: issue on 0..3, writeback on G_LATENCY..G_LATENCY+3.
      if (active) cnt_q <= half_last ? '0 : cnt_q + CW'(1);
      else        cnt_q <= '0;
      if (state_q == IDLE && Start_I)         round_q <= '0;
      else if (state_q == DIAG_WAIT && half_last) round_q <= round_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
      for (int i = 0; i < YD; i++) y_dly_q[i] <= '0;
    end else begin
      if (state_q == IDLE && Start_I) begin
        for (int i = 0; i < 16; i++) begin
          v_q[i] <= State_I[32*i +: 32];
          m_q[i] <= Msg_I[32*i +: 32];
        end
      end else begin
        if (wb) begin
          v_q[wb_q[3:0]]   <= G_A_I;
          v_q[wb_q[7:4]]   <= G_B_I;
          v_q[wb_q[11:8]]  <= G_C_I;
          v_q[wb_q[15:12]] <= G_D_I;
        end
        if (state_q == DIAG_WAIT && half_last) begin
          for (int i = 0; i < 16; i++) m_q[i] <= m_q[PERM[i]];
        end
      end
      // Not flushed between halves: zeros shift in on every non-issue cycle.
      y_dly_q[0] <= y_now;
      for (int i = 1; i < YD; i++) y_dly_q[i] <= y_dly_q[i-1];
    end
  end

`ifdef G_SCHED_FINALIZE_EN
  logic [31:0] h_q [8];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
    end else if (state_q == IDLE && Start_I) begin
      for (int i = 0; i < 8; i++) h_q[i] <= State_I[32*i +: 32];
    end
  end

  always_comb begin
    fin_state = '0;
    for (int i = 0; i < 8; i++) begin
      fin_state[32*i +: 32]     = v_q[i] ^ v_q[i+8];
      fin_state[32*(i+8) +: 32] = v_q[i+8] ^ h_q[i];
    end
  end
`else
  always_comb begin
    fin_state = '0;
    for (int i = 0; i < 16; i++) fin_state[32*i +: 32] = v_q[i];
  end
`endif

  assign Busy_O  = (state_q != IDLE);
  assign Done_O  = done_q;
  assign State_O = state_o_q;
  assign G_A_O   = issue ? v_q[iss_q[3:0]]   : '0;
  assign G_B_O   = issue ? v_q[iss_q[7:4]]   : '0;
  assign G_C_O   = issue ? v_q[iss_q[11:8]]  : '0;
  assign G_D_O   = issue ? v_q[iss_q[15:12]] : '0;
  assign G_X_O   = issue ? m_q[x_idx]        : '0;

  generate
    if (Y_OFFSET == 0) begin : g_y_direct
      assign G_Y_O = y_now;
    end else begin : g_y_delayed
      assign G_Y_O = y_dly_q[YD-1];
    end
  endgenerate

endmodule

// File: tb/tb_g_round_scheduler.sv
// Randomized bench for g_round_scheduler: G-unit stub plus a per-round software compression model.
module tb_g_round_scheduler;

  localparam int ROUNDS   = 7;
  localparam int LAT      = 3;
  localparam int YOFF     = 2;
  localparam int HALF     = 4 + LAT;
  localparam int DONE_CYC = 1 + 2 * ROUNDS * HALF;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start_I;
  logic [511:0] State_I, Msg_I;
  logic         Busy_O, Done_O;
  logic [511:0] State_O;
  logic [31:0]  G_A_O, G_B_O, G_C_O, G_D_O, G_X_O, G_Y_O;
  logic [31:0]  G_A_I, G_B_I, G_C_I, G_D_I;

  int checks = 0;
  int errors = 0;
  int job_no = 0;
  bit g_real = 1'b0;

  logic [511:0] exp_vec [0:DONE_CYC+1];
  logic [511:0] exp_state;

  int DQ [4][4] = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
  int PERM [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  g_round_scheduler #(.ROUNDS(ROUNDS), .G_LATENCY(LAT), .Y_OFFSET(YOFF)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start_I(Start_I), .State_I(State_I), .Msg_I(Msg_I),
    .Busy_O(Busy_O), .Done_O(Done_O), .State_O(State_O),
    .G_A_O(G_A_O), .G_B_O(G_B_O), .G_C_O(G_C_O), .G_D_O(G_D_O), .G_X_O(G_X_O), .G_Y_O(G_Y_O),
    .G_A_I(G_A_I), .G_B_I(G_B_I), .G_C_I(G_C_I), .G_D_I(G_D_I)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] ror(input logic [31:0] w, input int n);
    return (w >> n) | (w << (32 - n));
  endfunction

  function automatic logic [127:0] g_fn(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, c, d;
    a = a0 + b0 + x;  d = ror(d0 ^ a, 16);
    c = c0 + d;       b = ror(b0 ^ c, 12);
    a = a + b + y;    d = ror(d ^ a, 8);
    c = c + d;        b = ror(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  // G unit stub: 3-cycle pipe, Y sampled two cycles after the operands; identity when g_real=0.
  logic [159:0] s0, s1;
  logic [127:0] s2;
  always @(posedge Clk) begin
    s0 <= {G_X_O, G_D_O, G_C_O, G_B_O, G_A_O};
    s1 <= s0;
    s2 <= g_real ? g_fn(s1[31:0], s1[63:32], s1[95:64], s1[127:96], s1[159:128], G_Y_O) : s1[127:0];
  end
  assign G_A_I = s2[31:0];
  assign G_B_I = s2[63:32];
  assign G_C_I = s2[95:64];
  assign G_D_I = s2[127:96];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] obs_vec();
    return {318'd0, Done_O, Busy_O, G_Y_O, G_X_O, G_D_O, G_C_O, G_B_O, G_A_O};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Sequential software compression; records what each issue cycle must show and the final output.
  task automatic build_model(input logic [511:0] st, input logic [511:0] msg);
    logic [31:0]  v [16];
    logic [31:0]  m [16];
    logic [31:0]  t [16];
    logic [127:0] r;
    int qa, qb, qc, qd, xi, cyc;
    for (int c = 0; c <= DONE_CYC + 1; c++) exp_vec[c] = '0;
    for (int c = 1; c <= DONE_CYC; c++) exp_vec[c][192] = 1'b1;
    exp_vec[DONE_CYC + 1][193] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v[i] = st[32*i +: 32];
      m[i] = msg[32*i +: 32];
    end
    for (int rd = 0; rd < ROUNDS; rd++) begin
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < 4; k++) begin
          if (h == 0) begin
            qa = k; qb = 4 + k; qc = 8 + k; qd = 12 + k;
          end else begin
            qa = DQ[k][0]; qb = DQ[k][1]; qc = DQ[k][2]; qd = DQ[k][3];
          end
          xi  = 8 * h + 2 * k;
          cyc = 1 + (2 * rd + h) * HALF + k;
          exp_vec[cyc][159:0] = {m[xi], v[qd], v[qc], v[qb], v[qa]};
          exp_vec[cyc + YOFF][191:160] = m[xi + 1];
          if (g_real) begin
            r = g_fn(v[qa], v[qb], v[qc], v[qd], m[xi], m[xi + 1]);
            v[qa] = r[31:0]; v[qb] = r[63:32]; v[qc] = r[95:64]; v[qd] = r[127:96];
          end
        end
      end
      for (int i = 0; i < 16; i++) t[i] = m[i];
      for (int i = 0; i < 16; i++) m[i] = t[PERM[i]];
    end
`ifdef G_SCHED_FINALIZE_EN
    for (int i = 0; i < 8; i++) begin
      exp_state[32*i +: 32]     = v[i] ^ v[i + 8];
      exp_state[32*(i+8) +: 32] = v[i + 8] ^ st[32*i +: 32];
    end
`else
    for (int i = 0; i < 16; i++) exp_state[32*i +: 32] = v[i];
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the Done_O cycle (or after abort).
  task automatic run_job(input logic [511:0] st, input logic [511:0] msg, input bit real_g, input int abort_at);
    g_real = real_g;
    build_model(st, msg);
    job_no++;
    State_I = st;
    Msg_I   = msg;
    Start_I = 1'b1;
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      @(negedge Clk);
      check($sformatf("job%0d_cyc%0d", job_no, c), obs_vec(), exp_vec[c]);
      if (c == 1) begin
        Start_I = 1'b0;
        State_I = rand512();
        Msg_I   = rand512();
      end
      if (c == 50) Start_I = 1'b1;
      if (c == 51) Start_I = 1'b0;
      if (c == abort_at) begin
        #1 Rst_n = 1'b0;
        #1;
        check($sformatf("job%0d_abort_outs", job_no), obs_vec(), '0);
        check($sformatf("job%0d_abort_state", job_no), State_O, '0);
        return;
      end
    end
    check($sformatf("job%0d_state", job_no), State_O, exp_state);
  endtask

  logic [511:0] st, msg, b3;
  logic [255:0] kat;

  initial begin
    Rst_n   = 1'b0;
    Start_I = 1'b0;
    State_I = '0;
    Msg_I   = '0;
    repeat (3) @(negedge Clk);
    check("reset_outs", obs_vec(), '0);
    check("reset_state", State_O, '0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("idle_outs", obs_vec(), '0);

    for (int i = 0; i < 16; i++) begin
      st[32*i +: 32]  = i;
      msg[32*i +: 32] = 32'h100 + i;
    end
    run_job(st, msg, 1'b0, 0);

    b3 = '0;
    b3[255:0]   = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                   32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
    b3[383:256] = b3[127:0];
    b3[511:480] = 32'd11;
    run_job(b3, '0, 1'b1, 0);
`ifdef G_SCHED_FINALIZE_EN
    kat = {32'h62321fe4, 32'hca939acc, 32'hb712c1ad, 32'hc925cb9b,
           32'h49c9dc36, 32'hea4d40a0, 32'ha6a1f9f5, 32'hb94913af};
    check("blake3_empty_kat", {256'd0, State_O[255:0]}, {256'd0, kat});
`endif

    for (int j = 0; j < 3; j++) run_job(rand512(), rand512(), 1'b1, 0);

    st  = rand512();
    msg = rand512();
    run_job(st, msg, 1'b1, 40);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      check($sformatf("post_abort_idle%0d", j), obs_vec(), '0);
    end
    run_job(st, msg, 1'b1, 0);
    @(negedge Clk);
    check("final_idle", obs_vec(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
